// File: rtl/dm_pkg.sv
// Shared defaults and word type for the data-memory RAM.
package dm_pkg;
    localparam int MEM_SIZE    = 9;
    localparam int WORD_WIDTH  = 16;
    localparam int ADDR_LENGTH = 11;
    localparam int DATA_LENGTH = 16;

    typedef logic [WORD_WIDTH-1:0] word_t;
endpackage

// File: rtl/dm_addr_dec.sv
// Data-memory address decoder: flags out-of-range addresses and extracts the word index.
module dm_addr_dec #(
    parameter int MEM_SIZE    = dm_pkg::MEM_SIZE,
    parameter int ADDR_LENGTH = dm_pkg::ADDR_LENGTH
) (
    input  logic [ADDR_LENGTH-1:0] i_Addr,
    output logic                   in_range,
    output logic [MEM_SIZE-1:0]    idx
);
    import dm_pkg::*;

    assign idx = i_Addr[MEM_SIZE-1:0];

    // With no upper address bits every address maps onto a real word.
    if (ADDR_LENGTH > MEM_SIZE) begin : g_hi
        assign in_range = (i_Addr[ADDR_LENGTH-1:MEM_SIZE] == '0);
    end else begin : g_full
        assign in_range = 1'b1;
    end
endmodule

// File: rtl/dm_data_ram.sv
// Word-addressed single-port data memory with registered read (write-first on Wr&Rd).
// Optional o_Err out-of-range flag is enabled by defining DM_RAM_ERR_EN.
module dm_data_ram #(
    parameter int MEM_SIZE    = dm_pkg::MEM_SIZE,
    parameter int WORD_WIDTH  = dm_pkg::WORD_WIDTH,
    parameter int ADDR_LENGTH = dm_pkg::ADDR_LENGTH,
    parameter int DATA_LENGTH = dm_pkg::DATA_LENGTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [ADDR_LENGTH-1:0] i_Addr,
    input  logic [DATA_LENGTH-1:0] i_Data,
    input  logic                   Wr,
    input  logic                   Rd,
`ifdef DM_RAM_ERR_EN
    output logic [DATA_LENGTH-1:0] o_Data,
    output logic                   o_Err
`else
    output logic [DATA_LENGTH-1:0] o_Data
`endif
);
    import dm_pkg::*;

    localparam int DEPTH = 2 ** MEM_SIZE;

    if (ADDR_LENGTH < MEM_SIZE) begin : g_chk_addr
        $error("dm_data_ram: ADDR_LENGTH (%0d) must be >= MEM_SIZE (%0d)", ADDR_LENGTH, MEM_SIZE);
    end
    if (DATA_LENGTH != WORD_WIDTH) begin : g_chk_data
        $error("dm_data_ram: DATA_LENGTH (%0d) must equal WORD_WIDTH (%0d)", DATA_LENGTH, WORD_WIDTH);
    end
    if (WORD_WIDTH != $bits(word_t)) begin : g_chk_word
        $error("dm_data_ram: WORD_WIDTH (%0d) must match dm_pkg::word_t", WORD_WIDTH);
    end

    word_t               mem [DEPTH];
    logic                in_range;
    logic [MEM_SIZE-1:0] idx;

    dm_addr_dec #(
        .MEM_SIZE    (MEM_SIZE),
        .ADDR_LENGTH (ADDR_LENGTH)
    ) u_addr_dec (
        .i_Addr   (i_Addr),
        .in_range (in_range),
        .idx      (idx)
    );

    // Storage and read register; a read in the same cycle as a write returns the new data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            o_Data <= '0;
        end else begin
            if (Wr && in_range) begin
                mem[idx] <= i_Data;
            end
            if (Rd) begin
                if (!in_range) begin
                    o_Data <= '0;
                end else if (Wr) begin
                    o_Data <= i_Data;
                end else begin
                    o_Data <= mem[idx];
                end
            end
        end
    end

`ifdef DM_RAM_ERR_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_Err <= 1'b0;
        end else begin
            o_Err <= (Wr || Rd) && !in_range;
        end
    end
`endif
endmodule

// File: tb/tb_dm_data_ram.sv
// Directed testbench for dm_data_ram; also checks o_Err when DM_RAM_ERR_EN is defined.
module tb_dm_data_ram;
    logic        i_clk;
    logic        i_rst_n;
    logic [10:0] i_Addr;
    logic [15:0] i_Data;
    logic        Wr;
    logic        Rd;
    logic [15:0] o_Data;
`ifdef DM_RAM_ERR_EN
    logic        o_Err;
`endif

    int errs;
    int checks;

    dm_data_ram dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_Addr  (i_Addr),
        .i_Data  (i_Data),
        .Wr      (Wr),
        .Rd      (Rd),
`ifdef DM_RAM_ERR_EN
        .o_Data  (o_Data),
        .o_Err   (o_Err)
`else
        .o_Data  (o_Data)
`endif
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Apply one access for a single clock edge, leaving outputs sampled 1 time unit after it.
    task automatic op(input logic wr, input logic rd, input logic [10:0] addr, input logic [15:0] data);
        Wr     = wr;
        Rd     = rd;
        i_Addr = addr;
        i_Data = data;
        @(posedge i_clk);
        #1;
        Wr = 1'b0;
        Rd = 1'b0;
    endtask

    initial begin
        errs    = 0;
        checks  = 0;
        Wr      = 1'b0;
        Rd      = 1'b0;
        i_Addr  = '0;
        i_Data  = '0;
        i_rst_n = 1'b0;
        #3;
        chk("reset_data", o_Data, 16'h0000);
`ifdef DM_RAM_ERR_EN
        chk("reset_err", {15'd0, o_Err}, 16'h0000);
`endif
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        op(1'b0, 1'b1, 11'd1, 16'h0000);
        chk("rd_after_reset", o_Data, 16'h0000);

        op(1'b1, 1'b0, 11'd2, 16'h0034);
        chk("wr_no_rd_hold", o_Data, 16'h0000);
        op(1'b0, 1'b1, 11'd2, 16'h0000);
        chk("rd_addr2", o_Data, 16'h0034);

        op(1'b1, 1'b1, 11'd5, 16'hBEEF);
        chk("write_first", o_Data, 16'hBEEF);
        op(1'b0, 1'b1, 11'd2, 16'h0000);
        chk("rd_addr2_again", o_Data, 16'h0034);
        op(1'b0, 1'b1, 11'd5, 16'h0000);
        chk("rd_addr5", o_Data, 16'hBEEF);

        op(1'b1, 1'b0, 11'h200, 16'h1234);
        chk("oor_wr_hold", o_Data, 16'hBEEF);
`ifdef DM_RAM_ERR_EN
        chk("oor_wr_err", {15'd0, o_Err}, 16'h0001);
`endif
        op(1'b0, 1'b1, 11'd0, 16'h0000);
        chk("rd_addr0_not_aliased", o_Data, 16'h0000);
`ifdef DM_RAM_ERR_EN
        chk("err_clears", {15'd0, o_Err}, 16'h0000);
`endif
        op(1'b0, 1'b1, 11'd5, 16'h0000);
        chk("rd_addr5_pre_oor", o_Data, 16'hBEEF);
        op(1'b0, 1'b1, 11'h7FF, 16'h0000);
        chk("oor_rd_zero", o_Data, 16'h0000);
`ifdef DM_RAM_ERR_EN
        chk("oor_rd_err", {15'd0, o_Err}, 16'h0001);
`endif
        op(1'b1, 1'b1, 11'h201, 16'h5555);
        chk("oor_wr_rd_zero", o_Data, 16'h0000);
        op(1'b0, 1'b1, 11'd1, 16'h0000);
        chk("rd_addr1_not_aliased", o_Data, 16'h0000);

        op(1'b1, 1'b0, 11'd511, 16'hA5A5);
        op(1'b0, 1'b1, 11'd511, 16'h0000);
        chk("rd_top_word", o_Data, 16'hA5A5);

        op(1'b0, 1'b1, 11'd2, 16'h0000);
        chk("rd_addr2_before_hold", o_Data, 16'h0034);
        op(1'b1, 1'b0, 11'd2, 16'h0077);
        chk("hold_across_write", o_Data, 16'h0034);
        op(1'b0, 1'b0, 11'd5, 16'h0000);
        chk("idle_hold", o_Data, 16'h0034);
        op(1'b0, 1'b1, 11'd2, 16'h0000);
        chk("rd_addr2_new", o_Data, 16'h0077);

        // Assert reset asynchronously in the middle of a pending read.
        Rd     = 1'b1;
        i_Addr = 11'd2;
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("async_reset_data", o_Data, 16'h0000);
        #2;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        Rd = 1'b0;
        chk("rd_addr2_after_reset", o_Data, 16'h0000);
        op(1'b0, 1'b1, 11'd5, 16'h0000);
        chk("rd_addr5_after_reset", o_Data, 16'h0000);
        op(1'b0, 1'b1, 11'd511, 16'h0000);
        chk("rd_top_after_reset", o_Data, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
